// File: rtl/mult_pipe_rv.sv
// mult_pipe_rv: STAGES-deep pipelined RV M-extension multiplier (MUL/MULH/MULHSU/MULHU)
// with valid/ready handshake, tag passthrough, flush, and optional MULT_PERF_CNT_EN op counter.
module mult_pipe_rv #(
  parameter int XLEN   = 64,
  parameter int STAGES = 4,
  parameter int TAGW   = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_func,
  input  logic [TAGW-1:0] in_tag,
  input  logic [XLEN-1:0] mcand,
  input  logic [XLEN-1:0] mplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TAGW-1:0] out_tag,
  output logic [XLEN-1:0] product,
  output logic [31:0]     perf_ops
);

  localparam int CHUNK = XLEN / STAGES;
  localparam int ACCW  = 2 * XLEN + 2;
  localparam int PPW   = XLEN + CHUNK + 2;
  localparam int LAST  = STAGES - 1;

  logic            r_valid    [STAGES];
  logic [TAGW-1:0] r_tag      [STAGES];
  logic [1:0]      r_func     [STAGES];
  logic [XLEN:0]   r_mcandExt [STAGES];
  logic [XLEN-1:0] r_mplier   [STAGES];
  logic [ACCW-1:0] r_acc      [STAGES];

  logic                   w_srcValid    [STAGES];
  logic [TAGW-1:0]        w_srcTag      [STAGES];
  logic [1:0]             w_srcFunc     [STAGES];
  logic [XLEN:0]          w_srcMcandExt [STAGES];
  logic [XLEN-1:0]        w_srcMplier   [STAGES];
  logic [ACCW-1:0]        w_srcAcc      [STAGES];
  logic [CHUNK-1:0]       w_chunk       [STAGES];
  logic signed [CHUNK:0]  w_chunkExt    [STAGES];
  logic signed [PPW-1:0]  w_pp          [STAGES];
  logic [ACCW-1:0]        w_accNext     [STAGES];
  logic                   w_stall;
  logic                   w_unused;

  assign w_stall  = r_valid[LAST] && !out_ready;
  assign in_ready = !w_stall;

  // Stage s adds mcand_ext * chunk_s << (s*CHUNK); only a signed mplier's last chunk has a negative top bit.
  always_comb begin
    w_srcValid[0]    = in_valid;
    w_srcTag[0]      = in_tag;
    w_srcFunc[0]     = in_func;
    w_srcMcandExt[0] = {mcand[XLEN-1] & (in_func != 2'b11), mcand};
    w_srcMplier[0]   = mplier;
    w_srcAcc[0]      = '0;
    for (int s = 1; s < STAGES; s++) begin
      w_srcValid[s]    = r_valid[s-1];
      w_srcTag[s]      = r_tag[s-1];
      w_srcFunc[s]     = r_func[s-1];
      w_srcMcandExt[s] = r_mcandExt[s-1];
      w_srcMplier[s]   = r_mplier[s-1];
      w_srcAcc[s]      = r_acc[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      w_chunk[s]    = w_srcMplier[s][s*CHUNK +: CHUNK];
      w_chunkExt[s] = {(s == LAST) && !w_srcFunc[s][1] && w_chunk[s][CHUNK-1], w_chunk[s]};
      w_pp[s]       = PPW'($signed(w_srcMcandExt[s])) * PPW'(w_chunkExt[s]);
      w_accNext[s]  = w_srcAcc[s] + (ACCW'(w_pp[s]) << (s * CHUNK));
    end
  end

  // Data registers load only with a valid op so the output holds its last result across bubbles and flushes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s]    <= 1'b0;
        r_tag[s]      <= '0;
        r_func[s]     <= '0;
        r_mcandExt[s] <= '0;
        r_mplier[s]   <= '0;
        r_acc[s]      <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s] <= 1'b0;
      end
    end else if (!w_stall) begin
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s] <= w_srcValid[s];
        if (w_srcValid[s]) begin
          r_tag[s]      <= w_srcTag[s];
          r_func[s]     <= w_srcFunc[s];
          r_mcandExt[s] <= w_srcMcandExt[s];
          r_mplier[s]   <= w_srcMplier[s];
          r_acc[s]      <= w_accNext[s];
        end
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign out_tag   = r_tag[LAST];
  assign product   = (r_func[LAST] == 2'b00) ? r_acc[LAST][XLEN-1:0] : r_acc[LAST][2*XLEN-1:XLEN];

  assign w_unused = ^{r_mcandExt[LAST], r_mplier[LAST], r_acc[LAST][ACCW-1 -: 2]};

`ifdef MULT_PERF_CNT_EN
  logic [31:0] r_perfOps;

  // Counts output handshakes; flush does not clear it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_perfOps <= '0;
    end else if (out_valid && out_ready) begin
      r_perfOps <= r_perfOps + 32'd1;
    end
  end

  assign perf_ops = r_perfOps;
`else
  assign perf_ops = '0;
`endif

endmodule

// File: tb/tb_mult_pipe_rv.sv
// tb_mult_pipe_rv: directed and randomized bench for mult_pipe_rv against a queue-based
// transaction model with full-width signed/unsigned reference products.
module tb_mult_pipe_rv;

  localparam int XLEN   = 64;
  localparam int STAGES = 4;
  localparam int TAGW   = 6;
  localparam int W2     = 2 * XLEN + 2;

  logic            clock     = 1'b0;
  logic            reset     = 1'b0;
  logic            flush     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [1:0]      in_func   = '0;
  logic [TAGW-1:0] in_tag    = '0;
  logic [XLEN-1:0] mcand     = '0;
  logic [XLEN-1:0] mplier    = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [TAGW-1:0] out_tag;
  logic [XLEN-1:0] product;
  logic [31:0]     perf_ops;

  always #5 clock = ~clock;

  mult_pipe_rv #(.XLEN(XLEN), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_func   (in_func),
    .in_tag    (in_tag),
    .mcand     (mcand),
    .mplier    (mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .product   (product),
    .perf_ops  (perf_ops)
  );

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] prod;
    int              waitCycles;
  } entry_t;

  entry_t          modelQ[$];
  logic [XLEN-1:0] expProd   = '0;
  logic [TAGW-1:0] expTag    = '0;
  logic [31:0]     expPerf   = '0;
  bit              checking  = 1'b0;
  bit              killWatch = 1'b0;
  bit              sawKilled = 1'b0;
  int              assertCount = 0;
  int              failCount   = 0;

  // Exact product of the two extended operands, then the requested half.
  function automatic logic [XLEN-1:0] refMul(input logic [1:0] f, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [W2-1:0] sa;
    logic signed [W2-1:0] sb;
    logic signed [W2-1:0] full;
    if (f != 2'b11) sa = W2'($signed(a));
    else            sa = W2'(a);
    if (f[1] == 1'b0) sb = W2'($signed(b));
    else              sb = W2'(b);
    full = sa * sb;
    if (f == 2'b00) return full[XLEN-1:0];
    return full[2*XLEN-1:XLEN];
  endfunction

  function automatic bit modelHeadValid();
    return (modelQ.size() > 0) && (modelQ[0].waitCycles == 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each accepted op needs STAGES-1 further unstalled edges before it is presented.
  always @(posedge clock) begin
    bit     headValid;
    bit     stall;
    entry_t e;
    headValid = modelHeadValid();
    stall     = headValid && !out_ready;
    if (!reset) begin
      modelQ.delete();
      expProd = '0;
      expTag  = '0;
      expPerf = '0;
    end else begin
      if (headValid && out_ready) expPerf = expPerf + 32'd1;
      if (flush) begin
        modelQ.delete();
      end else if (!stall) begin
        if (headValid) void'(modelQ.pop_front());
        foreach (modelQ[i]) begin
          if (modelQ[i].waitCycles > 0) modelQ[i].waitCycles = modelQ[i].waitCycles - 1;
        end
        if (in_valid) begin
          e.tag        = in_tag;
          e.prod       = refMul(in_func, mcand, mplier);
          e.waitCycles = STAGES - 1;
          modelQ.push_back(e);
        end
      end
    end
  end

  task automatic checkOutput();
    bit hv;
    hv = modelHeadValid();
    if (hv) begin
      expProd = modelQ[0].prod;
      expTag  = modelQ[0].tag;
    end
    check("in_ready", 64'(in_ready), 64'(!(hv && !out_ready)));
    check("out_valid", 64'(out_valid), 64'(hv));
    check("out_tag", 64'(out_tag), 64'(expTag));
    check("product", 64'(product), 64'(expProd));
`ifdef MULT_PERF_CNT_EN
    check("perf_ops", 64'(perf_ops), 64'(expPerf));
`else
    check("perf_ops", 64'(perf_ops), 64'(0));
`endif
    if (killWatch && out_valid && (out_tag == 6'd7 || out_tag == 6'd8 || out_tag == 6'd9))
      sawKilled = 1'b1;
  endtask

  always @(negedge clock) begin
    if (checking) checkOutput();
  end

  task automatic applyStimulus(input logic v, input logic [1:0] f, input logic [TAGW-1:0] t,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic rdy, input logic fl);
    @(negedge clock);
    #1;
    in_valid  = v;
    in_func   = f;
    in_tag    = t;
    mcand     = a;
    mplier    = b;
    out_ready = rdy;
    flush     = fl;
  endtask

  function automatic logic [XLEN-1:0] randOp();
    logic [XLEN-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(XLEN-1){1'b0}}};
      3:       v = {1'b0, {(XLEN-1){1'b1}}};
      4:       v = XLEN'(1);
      default: v = XLEN'({$urandom, $urandom});
    endcase
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]      dFunc [5];
    logic [XLEN-1:0] dA    [5];
    logic [XLEN-1:0] dB    [5];
    logic [XLEN-1:0] allOnes;
    logic [XLEN-1:0] m20;

    allOnes = '1;
    m20     = XLEN'(-20);

    @(negedge clock);
    checking = 1'b1;
    @(negedge clock);
    #1 reset = 1'b1;

    check("pin MUL 2*3", 64'(refMul(2'b00, XLEN'(2), XLEN'(3))), 64'd6);
    check("pin MULH -1*-1", 64'(refMul(2'b01, allOnes, allOnes)), 64'd0);
    check("pin MUL -1*-1", 64'(refMul(2'b00, allOnes, allOnes)), 64'd1);
    check("pin MULHU -1*-1", 64'(refMul(2'b11, allOnes, allOnes)), 64'hFFFF_FFFF_FFFF_FFFE);
    check("pin MULHSU -20*5", 64'(refMul(2'b10, m20, XLEN'(5))), 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin MUL -20*5", 64'(refMul(2'b00, m20, XLEN'(5))), 64'hFFFF_FFFF_FFFF_FF9C);

    applyStimulus(1, 2'b00, 6'd5, XLEN'(2), XLEN'(3), 1, 0);
    applyStimulus(0, 2'b00, 6'd0, '0, '0, 1, 0);
    repeat (STAGES - 1) @(negedge clock);
    check("first op valid", 64'(out_valid), 64'd1);
    check("first op product", 64'(product), 64'd6);
    check("first op tag", 64'(out_tag), 64'd5);

    dFunc = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b00};
    dA    = '{allOnes, allOnes, allOnes, m20, m20};
    dB    = '{allOnes, allOnes, allOnes, XLEN'(5), XLEN'(5)};
    for (int i = 0; i < 5; i++) applyStimulus(1, dFunc[i], TAGW'(20 + i), dA[i], dB[i], 1, 0);
    repeat (STAGES + 2) applyStimulus(0, 2'b00, 6'd0, '0, '0, 1, 0);

    for (int i = 1; i <= 4; i++) applyStimulus(1, 2'b00, TAGW'(i), XLEN'(i), XLEN'(100), 0, 0);
    repeat (5) applyStimulus(0, 2'b00, 6'd0, '0, '0, 0, 0);
    check("stall holds tag 1", 64'(out_tag), 64'd1);
    check("stall in_ready", 64'(in_ready), 64'd0);
    check("stall product", 64'(product), 64'd100);
    repeat (STAGES + 2) applyStimulus(0, 2'b00, 6'd0, '0, '0, 1, 0);

    killWatch = 1'b1;
    applyStimulus(1, 2'b00, 6'd7, XLEN'(7), XLEN'(7), 1, 0);
    applyStimulus(1, 2'b00, 6'd8, XLEN'(8), XLEN'(8), 1, 0);
    applyStimulus(1, 2'b00, 6'd9, XLEN'(9), XLEN'(9), 1, 1);
    applyStimulus(1, 2'b00, 6'd10, XLEN'(11), XLEN'(13), 1, 0);
    applyStimulus(0, 2'b00, 6'd0, '0, '0, 1, 0);
    repeat (STAGES - 1) @(negedge clock);
    check("post-flush op valid", 64'(out_valid), 64'd1);
    check("post-flush op product", 64'(product), 64'd143);
    check("post-flush op tag", 64'(out_tag), 64'd10);
    repeat (STAGES) applyStimulus(0, 2'b00, 6'd0, '0, '0, 1, 0);
    killWatch = 1'b0;
    check("flushed tags never emerge", 64'(sawKilled), 64'd0);

    for (int i = 0; i < 16000; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                    TAGW'($urandom), randOp(), randOp(),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
      if (i == 8000) reset = 1'b0;
      else           reset = 1'b1;
    end
    repeat (STAGES + 4) applyStimulus(0, 2'b00, 6'd0, '0, '0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
